axis_skid_register: RTL

//  Full-throughput AXIS register slice (2-entry skid buffer) placed directly downstream of the

---
 rtl/axis_skid_register_pkg.sv | 16 +
 rtl/axis_skid_register_if.sv | 32 +++
 rtl/axis_skid_register.sv | 101 ++++++++++
 3 files changed

// File: rtl/axis_skid_register_pkg.sv
// Shared constants for the AXIS skid register slice: state encoding and packed payload width.
package axis_skid_register_pkg;

    typedef logic [1:0] skid_state_t;

    localparam skid_state_t SKID_EMPTY = 2'd0;
    localparam skid_state_t SKID_BUSY  = 2'd1;
    localparam skid_state_t SKID_FULL  = 2'd2;

    // tdata + tkeep + tstrb + tid + tdest + tuser + tlast + twakeup
    function automatic int axis_payload_width(input int data_w, input int tid_w,
                                              input int dest_w, input int user_per_byte);
        return data_w + 2 * (data_w / 8) + tid_w + dest_w + user_per_byte * (data_w / 8) + 2;
    endfunction

endpackage

// File: rtl/axis_skid_register_if.sv
// AXI4-Stream bus bundle; master drives payload and tvalid, slave drives tready.
interface axis_skid_register_if #(
    parameter int DataWidth        = 32,
    parameter int TidWidth         = 8,
    parameter int DestWidth        = 8,
    parameter int UserWidthPerByte = 1
);
    localparam int KeepWidth = DataWidth / 8;
    localparam int UserWidth = UserWidthPerByte * DataWidth / 8;

    logic [DataWidth-1:0] tdata;
    logic [KeepWidth-1:0] tkeep;
    logic [KeepWidth-1:0] tstrb;
    logic                 tvalid;
    logic                 tready;
    logic                 tlast;
    logic [TidWidth-1:0]  tid;
    logic [DestWidth-1:0] tdest;
    logic [UserWidth-1:0] tuser;
    logic                 twakeup;

    modport master (
        output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, twakeup,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser, twakeup,
        output tready
    );

endinterface

// File: rtl/axis_skid_register.sv
// Full-throughput AXIS register slice (main + skid entry); 1-cycle latency when empty.
// s_axis.tready is registered (low only when both entries are held), so no comb path crosses the slice.
module axis_skid_register
    import axis_skid_register_pkg::*;
#(
    parameter int DataWidth        = 32,
    parameter int TidWidth         = 8,
    parameter int DestWidth        = 8,
    parameter int UserWidthPerByte = 1,
    parameter bit RegEnable        = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_skid_register_if.slave  s_axis,
    axis_skid_register_if.master m_axis
);

    localparam int PayloadWidth = axis_payload_width(DataWidth, TidWidth, DestWidth, UserWidthPerByte);

    logic [PayloadWidth-1:0] s_pay;
    logic [PayloadWidth-1:0] m_pay;

    assign s_pay = {s_axis.tdata, s_axis.tkeep, s_axis.tstrb, s_axis.tlast,
                    s_axis.tid, s_axis.tdest, s_axis.tuser, s_axis.twakeup};

    assign {m_axis.tdata, m_axis.tkeep, m_axis.tstrb, m_axis.tlast,
            m_axis.tid, m_axis.tdest, m_axis.tuser, m_axis.twakeup} = m_pay;

    if (RegEnable) begin : g_reg
        skid_state_t             state_q, state_d;
        logic [PayloadWidth-1:0] main_q, main_d;
        logic [PayloadWidth-1:0] skid_q, skid_d;
        logic                    s_rdy, m_vld;
        logic                    s_acc, m_take;

        assign s_acc  = s_axis.tvalid & s_rdy;
        assign m_take = m_vld & m_axis.tready;

        always_ff @(posedge clk) begin
            if (rst) begin
                state_q <= SKID_EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
            end
        end

        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                SKID_EMPTY: begin
                    if (s_acc) begin
                        main_d  = s_pay;
                        state_d = SKID_BUSY;
                    end
                end
                SKID_BUSY: begin
                    if (s_acc && m_take) begin
                        main_d = s_pay;
                    end else if (s_acc) begin
                        // Consumer stalled: park the new beat behind the one on the output.
                        skid_d  = s_pay;
                        state_d = SKID_FULL;
                    end else if (m_take) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (m_take) begin
                        main_d  = skid_q;
                        state_d = SKID_BUSY;
                    end
                end
                default: state_d = SKID_EMPTY;
            endcase
        end

        // Ready comes from the state register only; rst forces it low while held.
        always_comb begin
            m_vld = (state_q != SKID_EMPTY);
            s_rdy = (state_q != SKID_FULL) && !rst;
        end

        assign m_pay         = main_q;
        assign m_axis.tvalid = m_vld;
        assign s_axis.tready = s_rdy;
    end else begin : g_wire
        logic unused_clk_rst;

        assign unused_clk_rst = clk ^ rst;
        assign m_pay          = s_pay;
        assign m_axis.tvalid  = s_axis.tvalid;
        assign s_axis.tready  = m_axis.tready;
    end

endmodule
